// File: rtl/mdu_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
// The pipeline side drives the request; the unit returns busy and HI/LO.
interface mdu_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, hi, lo);
  modport slave  (input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU responder with HI/LO architectural registers.
// The result is computed when the request is accepted and only becomes visible at commit.
module mdu_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic      clk,
  input  logic      reset,
  mdu_unit_if.slave bus
);
  localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES + 1) : 1;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   pend_hi_q, pend_hi_d;
  logic [WIDTH-1:0]   pend_lo_q, pend_lo_d;
  logic               pend_wr_q, pend_wr_d;

  logic signed [2*WIDTH-1:0] mul_s;
  logic        [2*WIDTH-1:0] mul_u;
  logic signed [2*WIDTH-1:0] ext_a_s, ext_b_s;
  logic        [WIDTH-1:0]   divisor_u;
  logic        [WIDTH-1:0]   quo_u, rem_u;
  logic        [WIDTH-1:0]   mag_a, mag_b, mag_q, mag_r;
  logic        [WIDTH-1:0]   quo_s, rem_s;
  logic                      a_neg, b_neg, div_zero;

  // Operand arithmetic, evaluated on the accepting edge's inputs.
  always_comb begin
    ext_a_s   = {{WIDTH{bus.a[WIDTH-1]}}, bus.a};
    ext_b_s   = {{WIDTH{bus.b[WIDTH-1]}}, bus.b};
    mul_s     = ext_a_s * ext_b_s;
    mul_u     = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};

    div_zero  = (bus.b == '0);
    divisor_u = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : bus.b;
    quo_u     = bus.a / divisor_u;
    rem_u     = bus.a % divisor_u;

    // Signed divide on magnitudes; the most-negative / -1 case wraps back to itself.
    a_neg     = bus.a[WIDTH-1];
    b_neg     = bus.b[WIDTH-1];
    mag_a     = a_neg ? (~bus.a + 1'b1) : bus.a;
    mag_b     = b_neg ? (~divisor_u + 1'b1) : divisor_u;
    mag_q     = mag_a / mag_b;
    mag_r     = mag_a % mag_b;
    quo_s     = (a_neg ^ b_neg) ? (~mag_q + 1'b1) : mag_q;
    rem_s     = a_neg ? (~mag_r + 1'b1) : mag_r;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_MULT, OP_MULTU: begin
              pend_hi_d = (bus.op == OP_MULT) ? mul_s[2*WIDTH-1:WIDTH] : mul_u[2*WIDTH-1:WIDTH];
              pend_lo_d = (bus.op == OP_MULT) ? mul_s[WIDTH-1:0]       : mul_u[WIDTH-1:0];
              pend_wr_d = 1'b1;
              cnt_d     = CNT_W'(MUL_CYCLES - 1);
              state_d   = RUN;
              busy_d    = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              pend_hi_d = (bus.op == OP_DIV) ? rem_s : rem_u;
              pend_lo_d = (bus.op == OP_DIV) ? quo_s : quo_u;
              pend_wr_d = !div_zero;
              cnt_d     = CNT_W'(DIV_CYCLES - 1);
              state_d   = RUN;
              busy_d    = 1'b1;
            end
            OP_MTHI: hi_d = bus.a;
            OP_MTLO: lo_d = bus.a;
            default: ;
          endcase
        end
      end
      RUN: begin
        // Requests arriving here, including on the commit edge, are dropped.
        if (cnt_q == '0) begin
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          pend_wr_d = 1'b0;
          state_d   = IDLE;
          busy_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule
